// File: rtl/mesh_term_tx_pkg.sv
// Shared definitions for the mesh terminal packet source: header field
// widths, the packed header layout and the edge-terminal address check.
package mesh_tx_pkg;

    localparam int NXT_W  = 8;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 4;
    localparam int MODE_W = 1;
    localparam int HDR_W  = 17;

    // Header fields in wire order, MSB first; payload follows below mode.
    typedef struct packed {
        logic [NXT_W-1:0]  nxt_jump;
        logic [ROW_W-1:0]  dest_row;
        logic [COL_W-1:0]  dest_col;
        logic [MODE_W-1:0] mode;
    } pkt_hdr_t;

    // A destination is legal when it is the broadcast code or a terminal on
    // the mesh rim (row 0 / ROWS+1 with an in-range column, or column
    // 0 / COLUMNS+1 with an in-range row), and is never this terminal itself.
    function automatic logic is_valid_dest(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] col,
        input int               rows,
        input int               cols,
        input int               src_row,
        input int               src_col,
        input logic [7:0]       bdcst
    );
        int   r;
        int   c;
        logic v;
        r = {28'd0, row};
        c = {28'd0, col};
        if ({row, col} == bdcst) begin
            v = 1'b1;
        end else if (((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= cols)) begin
            v = 1'b1;
        end else if (((c == 0) || (c == cols + 1)) && (r >= 1) && (r <= rows)) begin
            v = 1'b1;
        end else begin
            v = 1'b0;
        end
        if ((r == src_row) && (c == src_col)) begin
            v = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/mesh_term_tx_if.sv
// Request-side and router-side signals of one mesh terminal source.
// master: the packet source itself; slave: the requester/router side.
interface mesh_term_tx_if #(
    parameter int PAKG_SIZE = 32
);
    logic                 wr_en_i;
    logic [3:0]           dest_row_i;
    logic [3:0]           dest_col_i;
    logic                 mode_i;
    logic [PAKG_SIZE-18:0] payload_i;
    logic                 wr_ack_o;
    logic                 wr_err_o;
    logic                 full_o;
    logic [PAKG_SIZE-1:0] data_out_i_in;
    logic                 pndng_i_in;
    logic                 popin;
    logic                 overflow_o;
    logic                 underflow_o;

    modport master (
        input  wr_en_i, dest_row_i, dest_col_i, mode_i, payload_i, popin,
        output wr_ack_o, wr_err_o, full_o, data_out_i_in, pndng_i_in,
               overflow_o, underflow_o
    );

    modport slave (
        output wr_en_i, dest_row_i, dest_col_i, mode_i, payload_i, popin,
        input  wr_ack_o, wr_err_o, full_o, data_out_i_in, pndng_i_in,
               overflow_o, underflow_o
    );
endinterface

// File: rtl/mesh_term_tx_fifo.sv
// Synchronous packet FIFO with a registered head word and pending flag.
// A word pushed into an empty FIFO is presented one cycle after it is
// written; a push that replaces the last entry while it is being popped
// is forwarded straight to the head so pending never drops.
module mesh_tx_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_head,
    output logic          o_pndng,
    output logic          o_full,
    output logic [CW-1:0] o_count
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_head;
    logic          r_pndng;
    logic          r_full;

    logic [CW-1:0] w_cnt_after_pop;
    logic [CW-1:0] w_count_nxt;
    logic [AW-1:0] w_rp_nxt;
    logic          w_bypass;

    // Next occupancy/read pointer and the forward-on-replace condition.
    always_comb begin
        w_cnt_after_pop = r_count - CW'(i_pop);
        w_count_nxt     = w_cnt_after_pop + CW'(i_push);
        w_rp_nxt        = r_rp + AW'(i_pop);
        w_bypass        = i_pop && i_push && (w_cnt_after_pop == {CW{1'b0}});
    end

    // Storage array write; contents need no reset since count gates reads.
    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wp] <= i_din;
        end
    end

    // Pointers, occupancy and registered head presentation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wp    <= {AW{1'b0}};
            r_rp    <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            r_head  <= {DW{1'b0}};
            r_pndng <= 1'b0;
            r_full  <= 1'b0;
        end else begin
            r_wp    <= r_wp + AW'(i_push);
            r_rp    <= w_rp_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_bypass ? i_din : r_mem[w_rp_nxt];
            r_pndng <= (w_cnt_after_pop != {CW{1'b0}}) || w_bypass;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign o_head  = r_head;
    assign o_pndng = r_pndng;
    assign o_full  = r_full;
    assign o_count = r_count;

endmodule

// File: rtl/mesh_term_tx.sv
// Mesh terminal packet source: validates write requests against the rim
// address map, formats them into router words, buffers them and presents
// them with the pending/pop handshake.
// Optional build macro MESH_TX_STATS_EN adds saturating traffic counters.
module mesh_term_tx
    import mesh_tx_pkg::*;
#(
    parameter int         ROWS       = 4,
    parameter int         COLUMNS    = 4,
    parameter int         PAKG_SIZE  = 32,
    parameter int         FIFO_DEPTH = 16,
    parameter int         SRC_ROW    = 0,
    parameter int         SRC_COL    = 1,
    parameter logic [7:0] BDCST      = 8'hFF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mesh_term_tx_if.master bus
`ifdef MESH_TX_STATS_EN
    ,
    output logic [15:0]   tx_cnt_o,
    output logic [15:0]   drop_cnt_o,
    output logic [15:0]   bcast_cnt_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                 w_valid;
    logic                 w_room;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_reject;
    logic                 w_ovf_evt;
    logic                 w_udf_evt;
    pkt_hdr_t             w_hdr;
    logic [PAKG_SIZE-1:0] w_word;
    logic [PAKG_SIZE-1:0] w_head;
    logic                 w_pndng;
    logic                 w_full;
    logic [CW-1:0]        w_count;

    logic                 r_wr_ack;
    logic                 r_wr_err;
    logic                 r_ovf;
    logic                 r_udf;

    // Request classification, handshake qualification and word formatting.
    always_comb begin
        w_valid   = is_valid_dest(bus.dest_row_i, bus.dest_col_i, ROWS, COLUMNS,
                                  SRC_ROW, SRC_COL, BDCST);
        w_pop     = bus.popin && w_pndng;
        w_room    = (w_count != CW'(FIFO_DEPTH)) || w_pop;
        w_push    = bus.wr_en_i && w_valid && w_room;
        w_reject  = bus.wr_en_i && !w_valid;
        w_ovf_evt = bus.wr_en_i && w_valid && !w_room;
        w_udf_evt = bus.popin && !w_pndng;
        w_hdr.nxt_jump = 8'h00;
        w_hdr.dest_row = bus.dest_row_i;
        w_hdr.dest_col = bus.dest_col_i;
        w_hdr.mode     = bus.mode_i;
        w_word = {w_hdr, bus.payload_i};
    end

    mesh_tx_fifo #(
        .DW    (PAKG_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_word),
        .o_head  (w_head),
        .o_pndng (w_pndng),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // Per-request status pulses and sticky overflow/underflow flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ack <= w_push;
            r_wr_err <= w_reject;
            r_ovf    <= r_ovf | w_ovf_evt;
            r_udf    <= r_udf | w_udf_evt;
        end
    end

    assign bus.wr_ack_o      = r_wr_ack;
    assign bus.wr_err_o      = r_wr_err;
    assign bus.full_o        = w_full;
    assign bus.data_out_i_in = w_head;
    assign bus.pndng_i_in    = w_pndng;
    assign bus.overflow_o    = r_ovf;
    assign bus.underflow_o   = r_udf;

`ifdef MESH_TX_STATS_EN
    logic [15:0] r_tx_cnt;
    logic [15:0] r_drop_cnt;
    logic [15:0] r_bcast_cnt;
    logic        w_head_bcast;

    // Broadcast detection on the word currently being retired.
    always_comb begin
        w_head_bcast = (w_head[PAKG_SIZE-9 -: 8] == BDCST);
    end

    // Saturating counters of retired, dropped and retired-broadcast packets.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tx_cnt    <= 16'd0;
            r_drop_cnt  <= 16'd0;
            r_bcast_cnt <= 16'd0;
        end else begin
            if (w_pop && (r_tx_cnt != 16'hFFFF)) begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end else begin
                r_tx_cnt <= r_tx_cnt;
            end
            if ((w_ovf_evt || w_reject) && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
            if (w_pop && w_head_bcast && (r_bcast_cnt != 16'hFFFF)) begin
                r_bcast_cnt <= r_bcast_cnt + 16'd1;
            end else begin
                r_bcast_cnt <= r_bcast_cnt;
            end
        end
    end

    assign tx_cnt_o    = r_tx_cnt;
    assign drop_cnt_o  = r_drop_cnt;
    assign bcast_cnt_o = r_bcast_cnt;
`endif

endmodule

// File: tb/tb_mesh_term_tx.sv
// Scoreboard bench for mesh_term_tx: expected words are queued as requests
// are accepted and compared as the router side pops them.
module tb_mesh_term_tx;

    logic clk;
    logic rst;

    mesh_term_tx_if #(.PAKG_SIZE(32)) bus ();

`ifdef MESH_TX_STATS_EN
    logic [15:0] tx_cnt;
    logic [15:0] drop_cnt;
    logic [15:0] bcast_cnt;
`endif

    mesh_term_tx dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef MESH_TX_STATS_EN
        ,
        .tx_cnt_o    (tx_cnt),
        .drop_cnt_o  (drop_cnt),
        .bcast_cnt_o (bcast_cnt)
`endif
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkword(input logic [3:0] r, input logic [3:0] c,
                                           input logic m, input logic [14:0] p);
        return {8'h00, r, c, m, p};
    endfunction

    // kind: 0 accepted, 1 rejected (bad address), 2 dropped (full)
    task automatic send(input logic [3:0] r, input logic [3:0] c, input logic m,
                        input logic [14:0] p, input int kind);
        bus.wr_en_i = 1'b1; bus.dest_row_i = r; bus.dest_col_i = c;
        bus.mode_i = m; bus.payload_i = p;
        step();
        bus.wr_en_i = 1'b0;
        check("wr_ack", {31'd0, bus.wr_ack_o}, (kind == 0) ? 32'd1 : 32'd0);
        check("wr_err", {31'd0, bus.wr_err_o}, (kind == 1) ? 32'd1 : 32'd0);
        if (kind == 0) sb.push_back(mkword(r, c, m, p));
    endtask

    task automatic pop_one();
        logic [31:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check("pndng_at_pop", {31'd0, bus.pndng_i_in}, 32'd1);
        check("head_word", bus.data_out_i_in, e);
        bus.popin = 1'b1;
        step();
        bus.popin = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic fill16(input int base);
        for (int i = 0; i < 16; i++) begin
            send(4'd5, 4'((i % 4) + 1), 1'(i % 2), 15'(base + i * 3), 0);
        end
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] w;
        rst = 1'b1;
        bus.wr_en_i = 1'b0; bus.dest_row_i = 4'd0; bus.dest_col_i = 4'd0;
        bus.mode_i = 1'b0; bus.payload_i = 15'd0; bus.popin = 1'b0;
        do_reset();

        // reset state
        check("rst_pndng", {31'd0, bus.pndng_i_in}, 32'd0);
        check("rst_data", bus.data_out_i_in, 32'd0);
        check("rst_full", {31'd0, bus.full_o}, 32'd0);
        check("rst_ack", {31'd0, bus.wr_ack_o}, 32'd0);
        check("rst_err", {31'd0, bus.wr_err_o}, 32'd0);
        check("rst_ovf", {31'd0, bus.overflow_o}, 32'd0);
        check("rst_udf", {31'd0, bus.underflow_o}, 32'd0);

        // single request, one-cycle write-to-present
        send(4'd0, 4'd2, 1'b0, 15'h1234, 0);
        check("pndng_before_present", {31'd0, bus.pndng_i_in}, 32'd0);
        step();
        check("ack_pulse_end", {31'd0, bus.wr_ack_o}, 32'd0);
        check("first_pndng", {31'd0, bus.pndng_i_in}, 32'd1);
        check("first_word", bus.data_out_i_in, 32'h0002_1234);
        pop_one();
        check("pndng_after_pop", {31'd0, bus.pndng_i_in}, 32'd0);
        check("no_udf", {31'd0, bus.underflow_o}, 32'd0);

        // invalid destinations: interior, self, out of range
        send(4'd1, 4'd1, 1'b0, 15'h0001, 1);
        send(4'd0, 4'd1, 1'b1, 15'h0002, 1);
        send(4'd7, 4'd7, 1'b0, 15'h0003, 1);
        step();
        check("inv_pndng", {31'd0, bus.pndng_i_in}, 32'd0);
        check("inv_err_clear", {31'd0, bus.wr_err_o}, 32'd0);

        // 17 back-to-back with no pops: full after 16, 17th dropped
        for (int i = 0; i < 16; i++) begin
            send(4'd5, 4'((i % 4) + 1), 1'(i % 2), 15'(16'h0100 + i * 3), 0);
            check("full_during_fill", {31'd0, bus.full_o}, (i == 15) ? 32'd1 : 32'd0);
        end
        check("ovf_before_17th", {31'd0, bus.overflow_o}, 32'd0);
        send(4'd2, 4'd0, 1'b1, 15'h7ABC, 2);
        check("ovf_after_17th", {31'd0, bus.overflow_o}, 32'd1);
        check("full_after_17th", {31'd0, bus.full_o}, 32'd1);
        for (int i = 0; i < 16; i++) pop_one();
        check("drain_pndng", {31'd0, bus.pndng_i_in}, 32'd0);
        check("drain_full", {31'd0, bus.full_o}, 32'd0);

        // full FIFO: push and pop in the same cycle
        do_reset();
        fill16(16'h0200);
        step();
        check("full_pre_simul", {31'd0, bus.full_o}, 32'd1);
        e = sb.pop_front();
        check("simul_head", bus.data_out_i_in, e);
        w = mkword(4'd3, 4'd5, 1'b1, 15'h5A5A);
        bus.wr_en_i = 1'b1; bus.dest_row_i = 4'd3; bus.dest_col_i = 4'd5;
        bus.mode_i = 1'b1; bus.payload_i = 15'h5A5A; bus.popin = 1'b1;
        step();
        bus.wr_en_i = 1'b0; bus.popin = 1'b0;
        sb.push_back(w);
        check("simul_ack", {31'd0, bus.wr_ack_o}, 32'd1);
        check("simul_full", {31'd0, bus.full_o}, 32'd1);
        check("simul_ovf", {31'd0, bus.overflow_o}, 32'd0);
        check("simul_next_head", bus.data_out_i_in, sb[0]);
        for (int i = 0; i < 16; i++) pop_one();
        check("simul_drain_pndng", {31'd0, bus.pndng_i_in}, 32'd0);

        // one entry held: push and pop together keeps pending high
        send(4'd4, 4'd0, 1'b0, 15'h0F0F, 0);
        step();
        e = sb.pop_front();
        check("one_head", bus.data_out_i_in, e);
        w = mkword(4'd0, 4'd4, 1'b1, 15'h3C3C);
        bus.wr_en_i = 1'b1; bus.dest_row_i = 4'd0; bus.dest_col_i = 4'd4;
        bus.mode_i = 1'b1; bus.payload_i = 15'h3C3C; bus.popin = 1'b1;
        step();
        bus.wr_en_i = 1'b0; bus.popin = 1'b0;
        sb.push_back(w);
        check("one_pndng", {31'd0, bus.pndng_i_in}, 32'd1);
        check("one_new_word", bus.data_out_i_in, w);
        pop_one();
        check("one_pndng_end", {31'd0, bus.pndng_i_in}, 32'd0);

        // underflow, then reset mid-transfer with popin asserted
        bus.popin = 1'b1;
        step();
        bus.popin = 1'b0;
        check("udf_set", {31'd0, bus.underflow_o}, 32'd1);
        fill16(16'h0300);
        check("pre_rst_full", {31'd0, bus.full_o}, 32'd1);
        rst = 1'b1; bus.popin = 1'b1;
        step();
        step();
        rst = 1'b0; bus.popin = 1'b0;
        sb.delete();
        check("post_rst_udf", {31'd0, bus.underflow_o}, 32'd0);
        check("post_rst_pndng", {31'd0, bus.pndng_i_in}, 32'd0);
        check("post_rst_full", {31'd0, bus.full_o}, 32'd0);
        check("post_rst_data", bus.data_out_i_in, 32'd0);
        step();
        check("post_rst_discard", {31'd0, bus.pndng_i_in}, 32'd0);

`ifdef MESH_TX_STATS_EN
        // traffic counters
        send(4'd5, 4'd1, 1'b0, 15'h0011, 0);
        send(4'd5, 4'd2, 1'b0, 15'h0022, 0);
        send(4'd0, 4'd3, 1'b1, 15'h0033, 0);
        send(4'hF, 4'hF, 1'b0, 15'h0044, 0);
        send(4'hF, 4'hF, 1'b1, 15'h0055, 0);
        send(4'd1, 4'd2, 1'b0, 15'h0066, 1);
        step();
        for (int i = 0; i < 5; i++) pop_one();
        step();
        check("tx_cnt", {16'd0, tx_cnt}, 32'd5);
        check("bcast_cnt", {16'd0, bcast_cnt}, 32'd2);
        check("drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mesh_term_tx.md
Name: mesh_term_tx

Overview:
Hardware packet source for one mesh terminal. It sits on the terminal-input side of mesh_gnrtr, on the same pins the bench driver feeds today (data_out_i_in, pndng_i_in, popin).
- Packet requests enter from a local write port.
- Each request is validated against the edge-terminal address map, formatted into a PAKG_SIZE word and buffered.
- Words are presented to the router with the pending/pop handshake.
- Used standalone as an RTL traffic source, and as the synthesizable counterpart of the router's terminal receiver.

Parameters:
- ROWS, 4, mesh rows.
- COLUMNS, 4, mesh columns.
- PAKG_SIZE, 32, packet width in bits (≥ 24).
- FIFO_DEPTH, 16, buffered packets (power of two, ≥ 2).
- SRC_ROW, 0, this terminal's row address.
- SRC_COL, 1, this terminal's column address.
- BDCST, 8'hFF, broadcast {row,col} code.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- wr_en_i  in  1  packet request strobe
- dest_row_i  in  4  destination row
- dest_col_i  in  4  destination column
- mode_i  in  1  routing mode (0 row-first, 1 column-first)
- payload_i  in  PAKG_SIZE-17  payload
- wr_ack_o  out  1  request accepted this cycle
- wr_err_o  out  1  request rejected this cycle (bad address)
- full_o  out  1  buffer full
- data_out_i_in  out  PAKG_SIZE  head packet to router
- pndng_i_in  out  1  packet pending to router
- popin  in  1  router consumed head
- overflow_o  out  1  sticky: request dropped while full
- underflow_o  out  1  sticky: popin while empty

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset state:
  - Buffer empty.
  - data_out_i_in = 0, pndng_i_in = 0.
  - full_o = 0, wr_ack_o = 0, wr_err_o = 0.
  - Sticky flags cleared.
  - Reset mid-transfer discards all buffered packets; popin during reset is ignored.
- Packet format, MSB to LSB:
  - [PAKG_SIZE-1 -: 8] nxt_jump = 8'h00 (router overwrites)
  - [PAKG_SIZE-9 -: 4] dest_row
  - [PAKG_SIZE-13 -: 4] dest_col
  - [PAKG_SIZE-17] mode
  - [PAKG_SIZE-18:0] payload
- Address validity. A request is valid iff one of:
  - {dest_row,dest_col} == BDCST
  - dest_row ∈ {0, ROWS+1} and 1 ≤ dest_col ≤ COLUMNS
  - dest_col ∈ {0, COLUMNS+1} and 1 ≤ dest_row ≤ ROWS
  
  In addition, a destination equal to (SRC_ROW, SRC_COL) is invalid.
- Write side:
  - Valid request and not full: enqueue; wr_ack_o = 1 in the following cycle.
  - Invalid request: not enqueued; wr_err_o = 1 in the following cycle. Overflow takes no part in this decision.
  - Valid request while full with no same-cycle pop: dropped; overflow_o sets, wr_ack_o stays 0.
- Read side:
  - pndng_i_in = !empty, registered.
  - data_out_i_in = head word, registered and stable while pndng_i_in = 1 and popin = 0.
  - popin = 1 with pndng_i_in = 1: head retired; next word (or pndng_i_in = 0) visible the next cycle.
  - popin with pndng_i_in = 0: ignored; underflow_o sets.
- Latency: request accepted at edge N → pndng_i_in = 1 with that word after edge N+1 when previously empty (one-cycle write-to-present).
- Simultaneous events:
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push and pop when one entry is held: pndng_i_in stays 1, new word presented.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is $clog2(FIFO_DEPTH)+1 bits. full_o = (count == FIFO_DEPTH).

Optional Feature:
- Macro: MESH_TX_STATS_EN.
- Defined: adds outputs tx_cnt_o[15:0] (packets retired by popin), drop_cnt_o[15:0] (overflow plus invalid rejects) and bcast_cnt_o[15:0] (broadcast packets retired).
  - Counters saturate at 16'hFFFF.
  - Counters clear on rst_i.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mesh_tx_pkg holds:
  - Field widths and offsets: NXT_W=8, ROW_W=4, COL_W=4, MODE_W=1, HDR_W=17.
  - Typedef pkt_hdr_t (packed struct of the header fields).
  - Function is_valid_dest(row, col, ROWS, COLUMNS, src_row, src_col, bdcst).
- One sub-module, mesh_tx_fifo: synchronous FIFO holding the formatted words. It provides push/pop, count, full/empty and registered head output. The top level does address checking, formatting, flag logic and the optional stats.

Test Plan:
- Reset, then a single request (dest 0,2; mode 0; payload 15'h1234) → wr_ack_o pulses one cycle; next cycle pndng_i_in = 1 and data_out_i_in = 32'h0002_1234 (nxt_jump 8'h00, row 0, col 2, mode 0, payload 15'h1234); popin for one cycle → pndng_i_in = 0 the next cycle.
- Invalid destinations (1,1 interior; 0,1 self; 7,7 out of range) → wr_err_o pulses for each; pndng_i_in stays 0.
- 17 back-to-back valid requests with popin held at 0 → full_o = 1 after 16; the 17th is dropped and overflow_o = 1. Then drain 16 words with popin = 1 every cycle → words appear in request order.
- FIFO full, push and popin in the same cycle → count stays 16, overflow_o stays 0, head advances.
- popin with buffer empty → underflow_o = 1; a later rst_i clears it, along with pndng_i_in and full_o.
- With MESH_TX_STATS_EN: 3 unicast and 2 broadcast ({F,F}) requests drained, plus 1 invalid request → tx_cnt_o = 5, bcast_cnt_o = 2, drop_cnt_o = 1.
